// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared encodings and defaults for the fetch stage
package fetch_ctrl_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [1:0] PC_SEL_REG    = 2'b10;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_OUT  = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_target_gen.sv
// rtl/fetch_target_gen.sv - combinational next-PC target for a decode-stage redirect
module fetch_target_gen
    import fetch_ctrl_pkg::*;
(
    input  logic [1:0]  pc_sel,
    input  logic [31:0] dec_pc,
    input  logic [25:0] dec_imm26,
    input  logic [15:0] dec_imm16,
    input  logic [31:0] dec_rsd,
    output logic [31:0] target
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;

    // Jumps and branches are relative to the delay-slot address, not dec_pc itself.
    assign seq_pc = dec_pc + 32'd4;
    assign br_off = {{14{dec_imm16[15]}}, dec_imm16, 2'b00};

    always_comb begin
        target = seq_pc;
        case (pc_sel)
            PC_SEL_JUMP:   target = {seq_pc[31:28], dec_imm26, 2'b00};
            PC_SEL_REG:    target = dec_rsd;
            PC_SEL_BRANCH: target = seq_pc + br_off;
            default:       target = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: owns the PC, issues imem requests, hands words to decode
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] dec_pc,
    input  logic [25:0] dec_imm26,
    input  logic [15:0] dec_imm16,
    input  logic [31:0] dec_rsd,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_err
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] inflight_pc;
    logic        pend;
    logic        skip;

    logic [31:0] target;
    logic [31:0] issue_addr;
    logic [31:0] dslot_pc;
    logic        issue_block;
    logic        req_fire;
    logic        resp_fire;
    logic        capture;
    logic        misaligned;

    fetch_target_gen u_target_gen (
        .pc_sel    (pc_sel),
        .dec_pc    (dec_pc),
        .dec_imm26 (dec_imm26),
        .dec_imm16 (dec_imm16),
        .dec_rsd   (dec_rsd),
        .target    (target)
    );

    assign issue_addr  = (pend && !skip) ? tgt : pc;
    // A trapped target is never fetched; only the delay slot may still go out.
    assign issue_block = fetch_err && pend && !skip;
    assign req_fire    = (state == ST_REQ) && !issue_block && imem_gnt;
    assign resp_fire   = (state == ST_RESP) && imem_rvalid;
    assign capture     = dec_valid && (pc_sel != PC_SEL_SEQ) && (state != ST_HALT);
    assign dslot_pc    = dec_pc + 32'd4;
    assign misaligned  = target[1:0] != 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_REQ;
            ST_REQ: begin
                if (issue_block) begin
                    state_next = ST_HALT;
                end else if (imem_gnt) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (imem_rvalid) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (if_ready) begin
                    state_next = fetch_err ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = 32'd0;
        if_valid  = 1'b0;
        if (state == ST_REQ && !issue_block) begin
            imem_req  = 1'b1;
            imem_addr = {issue_addr[31:2], 2'b00};
        end
        if (state == ST_OUT) begin
            if_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            tgt         <= 32'd0;
            pend        <= 1'b0;
            skip        <= 1'b0;
            inflight_pc <= 32'd0;
            fetch_err   <= 1'b0;
            if_pc       <= 32'd0;
            if_instr    <= 32'd0;
        end else begin
            if (req_fire) begin
                inflight_pc <= issue_addr;
                if (pend && !skip) begin
                    pc   <= tgt + 32'd4;
                    pend <= 1'b0;
                end else begin
                    pc <= pc + 32'd4;
                end
                if (pend && skip) begin
                    skip <= 1'b0;
                end
            end
            // Capture is judged against the pre-grant pc; a same-cycle grant of
            // the delay slot means the slot is already consumed.
            if (capture) begin
                pend <= 1'b1;
                tgt  <= MISALIGN_TRAP ? target : {target[31:2], 2'b00};
                skip <= (pc == dslot_pc) && !(req_fire && issue_addr == dslot_pc);
                if (MISALIGN_TRAP && misaligned) begin
                    fetch_err <= 1'b1;
                end
            end
            if (resp_fire) begin
                if_pc    <= inflight_pc;
                if_instr <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] RPC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [1:0]  pc_sel;
    logic [31:0] dec_pc;
    logic [25:0] dec_imm26;
    logic [15:0] dec_imm16;
    logic [31:0] dec_rsd;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_err;

    logic        gnt_en = 1'b1;
    logic        hold_resp = 1'b0;
    logic        force_stale = 1'b0;
    logic        pend_rsp = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] issued[$];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RPC), .MISALIGN_TRAP(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dec_valid   (dec_valid),
        .pc_sel      (pc_sel),
        .dec_pc      (dec_pc),
        .dec_imm26   (dec_imm26),
        .dec_imm16   (dec_imm16),
        .dec_rsd     (dec_rsd),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .fetch_err   (fetch_err)
    );

    assign imem_gnt = imem_req & gnt_en;

    // Memory: grants combinationally, answers ~addr the cycle after a grant.
    always @(posedge clk) begin : imem_model
        logic        fire;
        logic        rst_seen;
        logic [31:0] a;
        fire     = imem_req && imem_gnt;
        rst_seen = !rst_n;
        a        = imem_addr;
        #1;
        if (rst_seen) pend_rsp = 1'b0;
        if (fire && !rst_seen) begin
            issued.push_back(a);
            pend_rsp  = 1'b1;
            pend_addr = a;
        end
        if (force_stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (pend_rsp && !hold_resp) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pend_addr;
            pend_rsp    = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    task automatic drive_idle();
        gnt_en = 1'b1; hold_resp = 1'b0; force_stale = 1'b0; if_ready = 1'b1;
        dec_valid = 1'b0; pc_sel = 2'b00; dec_pc = 32'd0;
        dec_imm26 = 26'd0; dec_imm16 = 16'd0; dec_rsd = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        issued.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_issued(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (issued.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        n_total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || fetch_err !== 1'b0)
            $display("FAIL reset_ctrl req=%b valid=%b err=%b want 0/0/0", imem_req, if_valid, fetch_err);
        else n_pass++;
        n_total++;
        if (imem_addr !== 32'd0 || if_pc !== 32'd0 || if_instr !== 32'd0)
            $display("FAIL reset_data addr=%h pc=%h instr=%h want 0", imem_addr, if_pc, if_instr);
        else n_pass++;
        issued.delete();
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== RPC)
            $display("FAIL reset_first_req req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic        exp_v;
        logic [31:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp_v = (c % 3 == 0);
            n_total++;
            if (if_valid !== exp_v)
                $display("FAIL seq_valid cycle %0d got %b want %b", c, if_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                exp_pc = RPC + 32'((c / 3 - 1) * 4);
                n_total++;
                if (if_pc !== exp_pc || if_instr !== ~exp_pc)
                    $display("FAIL seq_word cycle %0d pc=%h instr=%h want %h %h", c, if_pc, if_instr, exp_pc, ~exp_pc);
                else n_pass++;
            end
        end
        n_total++;
        if (issued.size() < 3 || issued[0] !== RPC || issued[1] !== RPC + 32'd4 || issued[2] !== RPC + 32'd8)
            $display("FAIL seq_addrs got %p want 40000000 40000004 40000008", issued);
        else n_pass++;
    endtask

    task automatic test_gnt_hold();
        do_reset();
        gnt_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++;
            if (imem_req !== 1'b1 || imem_addr !== RPC)
                $display("FAIL gnt_hold req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
            else n_pass++;
        end
        gnt_en = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (if_valid !== 1'b1 || if_pc !== RPC)
            $display("FAIL gnt_hold_deliver valid=%b pc=%h want 1 %h", if_valid, if_pc, RPC);
        else n_pass++;
    endtask

    task automatic test_branch();
        bit ok;
        do_reset();
        repeat (3) @(negedge clk);
        dec_valid = 1'b1; pc_sel = PC_SEL_BRANCH; dec_pc = RPC; dec_imm16 = 16'h0004;
        @(negedge clk);
        dec_valid = 1'b0;
        wait_issued(4, ok);
        n_total++;
        if (!ok) $display("FAIL branch_timeout issued %0d want 4", issued.size());
        else n_pass++;
        if (ok) begin
            n_total++;
            if (issued[1] !== 32'h4000_0004 || issued[2] !== 32'h4000_0014 || issued[3] !== 32'h4000_0018)
                $display("FAIL branch_order got %h %h %h want 40000004 40000014 40000018", issued[1], issued[2], issued[3]);
            else n_pass++;
        end
    endtask

    task automatic test_redirect_late(input logic [1:0] sel, input logic [31:0] dpc,
                                      input logic [25:0] imm26, input logic [31:0] rsd,
                                      input logic [31:0] exp_tgt);
        do_reset();
        repeat (5) @(negedge clk);
        dec_valid = 1'b1; pc_sel = sel; dec_pc = dpc; dec_imm26 = imm26; dec_rsd = rsd;
        @(negedge clk);
        dec_valid = 1'b0;
        n_total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4000_0004)
            $display("FAIL late_dslot sel=%b valid=%b pc=%h want 1 40000004", sel, if_valid, if_pc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== exp_tgt)
            $display("FAIL late_target sel=%b req=%b addr=%h want 1 %h", sel, imem_req, imem_addr, exp_tgt);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (imem_req !== 1'b1 || imem_addr !== exp_tgt + 32'd4)
            $display("FAIL late_after sel=%b addr=%h want %h", sel, imem_addr, exp_tgt + 32'd4);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        if_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if (if_valid !== 1'b1 || if_pc !== RPC || if_instr !== ~RPC || imem_req !== 1'b0)
                $display("FAIL stall_hold cycle %0d valid=%b pc=%h instr=%h req=%b want 1 %h %h 0",
                         c, if_valid, if_pc, if_instr, imem_req, RPC, ~RPC);
            else n_pass++;
        end
        if_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC + 32'd4)
            $display("FAIL stall_resume valid=%b req=%b addr=%h want 0 1 40000004", if_valid, imem_req, imem_addr);
        else n_pass++;
    endtask

    task automatic test_stale_resp();
        do_reset();
        hold_resp = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0)
            $display("FAIL stale_in_resp req=%b valid=%b want 0 0", imem_req, if_valid);
        else n_pass++;
        rst_n = 1'b0; gnt_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; force_stale = 1'b1;
        @(negedge clk);
        n_total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC)
            $display("FAIL stale_req valid=%b req=%b addr=%h want 0 1 %h", if_valid, imem_req, imem_addr, RPC);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (if_valid !== 1'b0)
            $display("FAIL stale_ignored valid=%b want 0", if_valid);
        else n_pass++;
        force_stale = 1'b0; hold_resp = 1'b0; gnt_en = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (if_valid !== 1'b1 || if_pc !== RPC || if_instr !== ~RPC)
            $display("FAIL stale_refetch valid=%b pc=%h instr=%h want 1 %h %h", if_valid, if_pc, if_instr, RPC, ~RPC);
        else n_pass++;
    endtask

    task automatic test_misalign();
        int quiet;
        do_reset();
        repeat (3) @(negedge clk);
        dec_valid = 1'b1; pc_sel = PC_SEL_REG; dec_pc = RPC; dec_rsd = 32'h4000_0002;
        @(negedge clk);
        dec_valid = 1'b0;
        n_total++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h4000_0004)
            $display("FAIL misalign_dslot err=%b req=%b addr=%h want 1 1 40000004", fetch_err, imem_req, imem_addr);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4000_0004)
            $display("FAIL misalign_deliver valid=%b pc=%h want 1 40000004", if_valid, if_pc);
        else n_pass++;
        quiet = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (imem_req === 1'b0 && if_valid === 1'b0) quiet++;
        end
        n_total++;
        if (quiet != 6 || issued.size() != 2 || fetch_err !== 1'b1)
            $display("FAIL misalign_halt quiet=%0d issued=%0d err=%b want 6 2 1", quiet, issued.size(), fetch_err);
        else n_pass++;
        do_reset();
        @(negedge clk);
        n_total++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL misalign_clear err=%b req=%b want 0 1", fetch_err, imem_req);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_sequential();
        test_gnt_hold();
        test_branch();
        test_redirect_late(PC_SEL_REG, RPC, 26'd0, 32'h4000_1000, 32'h4000_1000);
        test_redirect_late(PC_SEL_JUMP, 32'h4FFF_FFFC, 26'h000_0010, 32'd0, 32'h5000_0040);
        test_stall();
        test_stale_resp();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
